// File: rtl/gpio_intr_gateway_if.sv
// Core-facing bundle for the GPIO interrupt gateway.
// master: CSR/bus glue side; drives raw lines, modes, enables and the claim/complete strobes.
// slave : the gateway; returns irq_o and irq_id_o.
interface gpio_intr_gateway_if #(
  parameter int NumSrc = 32,
  parameter int IdW    = $clog2(NumSrc + 1)
);
  logic [NumSrc-1:0] intr_src_i;
  logic [NumSrc-1:0] src_le_i;
  logic [NumSrc-1:0] src_en_i;
  logic              claim_i;
  logic              complete_i;
  logic [IdW-1:0]    complete_id_i;
  logic              irq_o;
  logic [IdW-1:0]    irq_id_o;

  modport master (
    output intr_src_i, src_le_i, src_en_i, claim_i, complete_i, complete_id_i,
    input  irq_o, irq_id_o
  );

  modport slave (
    input  intr_src_i, src_le_i, src_en_i, claim_i, complete_i, complete_id_i,
    output irq_o, irq_id_o
  );
endinterface

// File: rtl/gpio_intr_gateway.sv
// Per-source interrupt gateway with lowest-index priority selection.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low reset
//   bus    - gpio_intr_gateway_if.slave: raw lines, per-source mode/enable,
//            claim/complete strobes in; irq_o / irq_id_o out (registered).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no request outstanding; a trigger moves it to PENDING
// ST_PENDING  | requesting; presented when enabled and highest priority
// ST_INFLIGHT | claimed by software; waits for complete, may queue one edge
module gpio_intr_gateway #(
  parameter int NumSrc = 32,
  parameter int IdW    = $clog2(NumSrc + 1)
) (
  input logic                clk_i,
  input logic                rst_ni,
  gpio_intr_gateway_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_INFLIGHT = 2'd2
  } state_e;

  state_e            state_q [NumSrc];
  state_e            state_d [NumSrc];
  logic [NumSrc-1:0] edge_seen_q, edge_seen_d;
  logic [NumSrc-1:0] src_q, src_d;
  logic              irq_q, irq_d;
  logic [IdW-1:0]    irq_id_q, irq_id_d;

  logic [NumSrc-1:0] rise, trig, claim_hit, comp_hit;
  logic [NumSrc-1:0] pending_next, sel;

  // Trigger and strobe decode. A claim only lands on the source currently
  // presented, so it is matched against the registered outputs.
  always_comb begin
    src_d     = bus.intr_src_i;
    rise      = bus.intr_src_i & ~src_q;
    trig      = (bus.src_le_i & rise) | (~bus.src_le_i & bus.intr_src_i);
    claim_hit = '0;
    comp_hit  = '0;
    for (int i = 0; i < NumSrc; i++) begin
      claim_hit[i] = bus.claim_i & irq_q & (irq_id_q == IdW'(i + 1));
      comp_hit[i]  = bus.complete_i & (bus.complete_id_i == IdW'(i + 1));
    end
  end

  // Next-state logic, one small FSM per source.
  always_comb begin
    edge_seen_d = edge_seen_q;
    for (int i = 0; i < NumSrc; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trig[i]) state_d[i] = ST_PENDING;
        end
        ST_PENDING: begin
          if (claim_hit[i]) state_d[i] = ST_INFLIGHT;
        end
        ST_INFLIGHT: begin
          if (comp_hit[i]) begin
            // A queued edge or a still-asserted level re-requests at once.
            if (edge_seen_q[i] || (!bus.src_le_i[i] && bus.intr_src_i[i])) begin
              state_d[i] = ST_PENDING;
            end else begin
              state_d[i] = ST_IDLE;
            end
            edge_seen_d[i] = 1'b0;
          end else if (bus.src_le_i[i] && rise[i]) begin
            edge_seen_d[i] = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Output logic: select from the post-update pending vector so the
  // registered outputs reflect the state after this edge.
  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      pending_next[i] = (state_d[i] == ST_PENDING);
    end
    sel      = pending_next & bus.src_en_i;
    irq_d    = |sel;
    irq_id_d = '0;
    // Scan high to low so the lowest index is written last and wins.
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (sel[i]) irq_id_d = IdW'(i + 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSrc; i++) begin
        state_q[i] <= ST_IDLE;
      end
      edge_seen_q <= '0;
      src_q       <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      for (int i = 0; i < NumSrc; i++) begin
        state_q[i] <= state_d[i];
      end
      edge_seen_q <= edge_seen_d;
      src_q       <= src_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign bus.irq_o    = irq_q;
  assign bus.irq_id_o = irq_id_q;

endmodule

// File: doc/gpio_intr_gateway.md
# gpio_intr_gateway

Per-source interrupt gateway and priority selector that consumes the 32 `intr_gpio_o` lines of the GPIO block and presents a single external interrupt with a source ID to the core. Each source runs a small IDLE/PENDING/INFLIGHT state machine. Level or edge capture is selectable per source, and a source cannot re-request until software completes it. Claim and complete are single-cycle strobes driven by the core-side CSR/bus glue.

## Interface

- `NumSrc`, default 32: number of interrupt sources; source `i` carries ID `i+1`.
- `IdW`, default 6: ID width, `$clog2(NumSrc+1)`; ID 0 means "none".
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset; synchronous, active-low.
- `intr_src_i`  in  NumSrc: raw interrupt lines (from GPIO `intr_gpio_o`).
- `src_le_i`  in  NumSrc: per-source mode; 1 = rising-edge, 0 = level-high.
- `src_en_i`  in  NumSrc: per-source enable for selection only.
- `claim_i`  in  1: one-cycle claim strobe.
- `complete_i`  in  1: one-cycle completion strobe.
- `complete_id_i`  in  IdW: ID being completed.
- `irq_o`  out  1: at least one enabled source is PENDING.
- `irq_id_o`  out  IdW: ID of the selected source; 0 when `irq_o`=0.

## Operation

- **Reset** (`rst_ni`=0 at a clock edge):
  - All sources go to IDLE.
  - `edge_seen` and `src_q` clear.
  - `irq_o`=0 and `irq_id_o`=0.
- **Trigger:**
  - `trig[i] = src_le_i[i] ? (intr_src_i[i] & ~src_q[i]) : intr_src_i[i]`.
  - `src_q` registers `intr_src_i` every cycle.
- **IDLE → PENDING** when `trig[i]`.
- **PENDING → INFLIGHT** when `claim_i`=1, `irq_o`=1 and `irq_id_o`==i+1. Only the presented source moves.
- **INFLIGHT, before completion:**
  - An edge-mode trigger sets `edge_seen[i]`.
  - Level-mode triggers are ignored.
- **INFLIGHT → completion** when `complete_i`=1 and `complete_id_i`==i+1:
  - Goes to PENDING if `edge_seen[i]`, or if level mode with `intr_src_i[i]`=1.
  - Otherwise goes to IDLE.
  - `edge_seen[i]` clears in either case.
- **Triggers while PENDING** are absorbed; there is no counting beyond one queued edge.
- **Ignored completes:** a complete with ID 0, ID >NumSrc, or ID of a non-INFLIGHT source has no effect.
- **Claim while `irq_o`=0:** no effect.
- **Selection:**
  - Winner is the lowest-index source with `pending_next & src_en_i`.
  - `pending_next` is the post-update PENDING vector.
  - `irq_id_o` is the winner index + 1; `irq_o` = any winner.
- **Disabled sources:**
  - A disabled source keeps its PENDING state; it is simply not presented.
  - Re-enabling presents it with no new trigger.
- **Claim and complete in the same cycle** are both processed. They cannot target the same source, because the claimed source is PENDING and the completed one is INFLIGHT.
- **Mode change:** changing `src_le_i` affects triggers from the next edge; the state is kept.

## Timing

- **Output registers:** `irq_o` and `irq_id_o` are registered from next-state values, so they reflect the state after the current edge.
- **Trigger to `irq_o`:** a trigger sampled at edge k gives PENDING and `irq_o`/`irq_id_o` valid after edge k (1-cycle latency from input).
- **Claim:** a claim at edge m shows the next winner, or 0, after edge m. Back-to-back claims on consecutive cycles therefore take distinct sources.
- **Complete with re-request:** a complete at edge m with the condition still active makes the source PENDING after edge m and eligible immediately.
- **Edge detection:**
  - `src_q` resets to 0, so an input already high when reset is released counts as a rising edge at the first active edge.
  - A level that stays high produces exactly one edge.
- **Combinational paths:** none from inputs to outputs.

## Test plan

- **Level basic:** reset, then `src_le_i`=0, `src_en_i`=all 1, assert `intr_src_i[4]` at edge 1 → after edge 1 `irq_o`=1, `irq_id_o`=5.
  - Claim at edge 3 → `irq_o`=0, `irq_id_o`=0.
  - Complete ID 5 with the line still high → `irq_o`=1, ID 5 after the same edge.
  - Complete with the line low → stays 0.
- **Priority and back-to-back claims:** sources 2 and 9 triggered together → ID 3.
  - Claim → ID 10 next cycle.
  - Claim again → ID 0.
  - Complete ID 10 then ID 3 → both return to IDLE (edge mode, lines held high, no new edges).
- **Edge queueing:** `src_le_i[0]`=1; pulse, claim (ID 1), then pulse twice while INFLIGHT → on complete ID 1 the source is PENDING again. After a second claim/complete with no further pulses → IDLE.
- **Enable masking:** pulse source 7 with `src_en_i[7]`=0 → `irq_o`=0.
  - Set `src_en_i[7]`=1 → `irq_o`=1, ID 8 the next cycle.
  - Claim while `irq_o`=0 earlier → no state change.
- **Bogus completes and reset:**
  - Complete ID 0, ID 33, or an IDLE source → no change.
  - Assert `rst_ni`=0 with sources PENDING/INFLIGHT → after that edge `irq_o`=0 and `irq_id_o`=0.
  - Held-high level input after reset release → `irq_o`=1 one edge later.
